// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
package piso_serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int   DEFAULT_WIDTH      = 8;
  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_serializer_datapath.sv
// Shift register and bit counter for the serializer; LSB leaves first.
module piso_datapath
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;

  // The counter parks on the last index when a frame ends; only a reload restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
      if (bit_cnt != LAST_IDX) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign lsb  = shreg[0];
  assign last = (bit_cnt == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready load, LSB-first shift-out,
// done pulse after the last bit, back-to-back frames without an idle gap.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  state_t state, state_next;
  logic   lsb, last;
  logic   load, shift, last_bit;

  assign load     = load_valid && load_ready;
  assign last_bit = (state == S_SHIFT) && shift_en && last;

  piso_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (din),
    .lsb   (lsb),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= last_bit;
    end
  end

  // Accepting a word on the last-bit edge keeps the machine in SHIFT for a seamless next frame.
  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    sout       = IDLE_LEVEL;
    sout_valid = 1'b0;
    busy       = 1'b0;
    shift      = 1'b0;
    case (state)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sout       = lsb;
        sout_valid = 1'b1;
        busy       = 1'b1;
        shift      = shift_en;
        if (shift_en && last) begin
          load_ready = 1'b1;
          state_next = load_valid ? S_SHIFT : S_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: a word-level model queues expected bits,
// a negedge monitor pops and compares them along with the control outputs.
module tb_piso_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = 8'hFF;
  logic             load_valid = 1'b1;
  logic             load_ready;
  logic             shift_en = 1'b1;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  int   n_vec = 0;
  int   n_bad = 0;
  bit   checking = 1'b0;
  int   model_left = 0;
  bit   model_done = 1'b0;
  bit   exp_q[$];
  logic [WIDTH-1:0] rx = '0;

  piso_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .shift_en   (shift_en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Serial-in shift-right receiver sharing the clock, enable tied high.
  always @(posedge clk) rx <= {sout, rx[WIDTH-1:1]};

  task automatic checkOutput(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic lv, input logic [WIDTH-1:0] d,
                               input logic se);
    @(posedge clk);
    #1;
    rst        = r;
    load_valid = lv;
    din        = d;
    shift_en   = se;
  endtask

  // Word-level reference: a frame is WIDTH enabled bit times; a new word is taken
  // when idle or when the final bit is being consumed.
  always @(posedge clk) begin
    if (rst) begin
      checking   = 1'b1;
      model_left = 0;
      model_done = 1'b0;
      exp_q.delete();
    end else begin
      bit accept;
      accept     = load_valid && ((model_left == 0) || (shift_en && model_left == 1));
      model_done = (model_left == 1) && shift_en;
      if (model_left > 0 && shift_en) model_left--;
      if (accept) begin
        model_left = WIDTH;
        for (int i = 0; i < WIDTH; i++) exp_q.push_back(din[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      bit exp_valid, exp_ready, exp_bit;
      exp_valid = (model_left > 0);
      exp_ready = (model_left == 0) || (shift_en && model_left == 1);
      exp_bit   = 1'b0;
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("[TB] FAIL scoreboard_empty at %0t: got no queued bit expected one", $time);
        end else begin
          exp_bit = exp_q[0];
        end
      end
      checkOutput("sout", sout, exp_bit);
      checkOutput("sout_valid", sout_valid, exp_valid);
      checkOutput("busy", busy, exp_valid);
      checkOutput("load_ready", load_ready, exp_ready);
      checkOutput("done", done, model_done);
      if (exp_valid && shift_en && !rst && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    bit found;
    int lat;

    // Reset held two edges with a word offered: nothing may be taken.
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Single frame, then confirm the receiver holds the word when done fires.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
    found = 1'b0;
    lat   = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        lat   = i;
        break;
      end
    end
    n_vec++;
    if (!found || rx !== 8'hA5 || lat != WIDTH) begin
      n_bad++;
      $display("[TB] FAIL rx_word: got rx=%h latency=%0d expected rx=a5 latency=%0d",
               rx, lat, WIDTH);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Back-to-back: second word is offered through the first frame.
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1);
    repeat (WIDTH) applyStimulus(1'b0, 1'b1, 8'hC3, 1'b1);
    repeat (12) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Pacing with shift_en toggling.
    applyStimulus(1'b0, 1'b1, 8'h81, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 8'h00, logic'(i % 2));
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Busy load rejection.
    applyStimulus(1'b0, 1'b1, 8'h0F, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hF0, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Mid-frame reset, then a clean frame.
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b1);
    repeat (12) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(logic'($urandom_range(199) == 0), logic'($urandom_range(1)),
                    WIDTH'($urandom), logic'($urandom_range(3) != 0));
    end
    repeat (20) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter; the sending end of the team's 8-bit serial-in shift-right register.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out LSB-first on sout, one bit per enabled clock.
- Flags the frame with sout_valid and pulses done when the last bit has been sent.
- With sout driving the receiver's sin, identical clk and shift_en tied high, the receiver's parallel output equals the loaded word WIDTH edges after the load edge.

Parameters:
- WIDTH, 8, word length in bits (>= 2).
- IDLE_LEVEL, 1'b0, value driven on sout when no frame is active.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  a word is offered on din.
- load_ready  output  1  combinational; serializer can accept a word this cycle.
- shift_en  input  1  bit-rate enable; when low, all frame state holds.
- sout  output  1  serial data, LSB first.
- sout_valid  output  1  high while sout carries a frame bit.
- busy  output  1  high in SHIFT state.
- done  output  1  one-cycle registered pulse after the last bit is consumed.

Behaviour:
- State machine has two states:
  - IDLE: load_ready=1, sout=IDLE_LEVEL, sout_valid=0, busy=0.
  - SHIFT: sout=shreg[0], sout_valid=1, busy=1.
- Registers: shreg[WIDTH-1:0], bit_cnt[$clog2(WIDTH)-1:0], state, done.
- Reset (synchronous, rst=1 at posedge) sets:
  - state=IDLE, shreg=0, bit_cnt=0, done=0.
  - Resulting outputs: sout=IDLE_LEVEL, sout_valid=0, busy=0, load_ready=1.
- rst has priority over every other input.
- Load (edge where load_valid && load_ready):
  - shreg<=din, bit_cnt<=0, state<=SHIFT.
  - din[0] appears on sout after that edge; receiver samples it on the next edge.
- Shift (edge where state==SHIFT && shift_en, no load):
  - shreg<={1'b0, shreg[WIDTH-1:1]}, bit_cnt<=bit_cnt+1.
- Last bit (state==SHIFT && shift_en && bit_cnt==WIDTH-1):
  - Next edge sets done<=1 for exactly one cycle and state<=IDLE.
  - Exception: if a load is accepted on that same edge, state stays SHIFT with the new word (back-to-back).
  - done still pulses in the back-to-back case.
- load_ready = (state==IDLE) || (state==SHIFT && shift_en && bit_cnt==WIDTH-1).
- Back-to-back frames therefore have no idle gap: sout_valid stays high continuously.
- shift_en low in SHIFT: shreg, bit_cnt and state hold; sout is stable; load_ready=0; done=0.
- shift_en has no effect in IDLE; a load in IDLE is accepted regardless of shift_en.
- load_valid while busy and not on the last bit: load_ready=0, word ignored, no state change.
- A frame occupies exactly WIDTH enabled cycles.
  - Latency from load edge to done assertion = WIDTH enabled edges + 0 cycles (done is high in the cycle after the last-bit edge).
- Reset mid-frame: frame aborted, no done pulse, sout returns to IDLE_LEVEL the cycle after the reset edge.
- bit_cnt never exceeds WIDTH-1; there is no wrap path other than reload.
- All outputs are free of X after the first reset edge.

Decomposition:
- Shared package holds:
  - State encoding constants: S_IDLE=1'b0, S_SHIFT=1'b1.
  - Default WIDTH=8.
  - IDLE_LEVEL default.
- One sub-module, piso_datapath, holds shreg and bit_cnt. Its inputs are load, shift, din; its outputs are lsb and last (bit_cnt==WIDTH-1).
- FSM, handshake logic and done register stay in the top level.

Test Plan:
- Reset: assert rst for 2 cycles with load_valid=1, din=8'hFF -> sout=0, sout_valid=0, busy=0, done=0, load_ready=1 after reset; no load taken.
- Single frame: load din=8'hA5 with shift_en=1 -> sout over 8 cycles = 1,0,1,0,0,1,0,1. done is high for one cycle only, the cycle after the 8th bit. A serial-in shift-right receiver on the same clk holds 8'hA5 at that point.
- Back-to-back: hold load_valid=1 with 8'h3C, then 8'hC3 presented during the last bit -> 16 contiguous valid bits 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1. sout_valid never drops; two done pulses 8 cycles apart.
- Pacing: load 8'h81 and toggle shift_en every other cycle -> each bit held 2 cycles; frame length 16 cycles; bit order unchanged. load_ready stays low while shift_en=0 on the last bit.
- Busy load rejection: load 8'h0F, then present load_valid with 8'hF0 at bit 3 -> second word ignored; full 8'h0F frame emitted; load_ready=0 during bits 0..6.
- Mid-frame reset: load 8'h55 and pulse rst at bit 4 -> next cycle sout=0, sout_valid=0, busy=0. No done pulse; a subsequent load of 8'h01 transmits cleanly.
